// File: rtl/sramx_arbiter_if.sv
// Request/response types and the split-handshake bus interface used by sramx_arbiter.
// The arbiter faces masters through the slave modport and the shared slave through the master modport.
package sramx_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } resp_t;

endpackage

interface sramx_arbiter_if;
  import sramx_arbiter_pkg::*;

  req_t  req;
  resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/sramx_arbiter.sv
// Two-master to one-slave sramx arbiter with an owner-ID FIFO steering in-order data_ok back.
// Define SRAMX_ARB_RR_EN for round-robin grant; otherwise master 0 (dbus) has fixed priority.
module sramx_arbiter
  import sramx_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            resetn,
  sramx_arbiter_if.slave  m0,
  sramx_arbiter_if.slave  m1,
  sramx_arbiter_if.master s,
  output logic            busy,
  output logic            err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic [PW-1:0]              head;
  logic [PW-1:0]              tail;
  logic [CW-1:0]              count;
  logic [MAX_OUTSTANDING-1:0] fifo;
  logic                       lock;
  logic                       lock_id;
`ifdef SRAMX_ARB_RR_EN
  logic                       rr;
`endif

  logic has_grant;
  logic grant_id;
  logic grant_valid;
  logic issue_ok;
  logic s_valid;
  logic push;
  logic pop;
  logic head_id;

  // A locked request keeps the bus even if a higher-priority master shows up.
  always_comb begin
    has_grant = 1'b0;
    grant_id  = 1'b0;
    if (lock) begin
      has_grant = 1'b1;
      grant_id  = lock_id;
    end
`ifdef SRAMX_ARB_RR_EN
    else if (m0.req.valid && m1.req.valid) begin
      has_grant = 1'b1;
      grant_id  = ~rr;
    end
`endif
    else if (m0.req.valid) begin
      has_grant = 1'b1;
      grant_id  = 1'b0;
    end else if (m1.req.valid) begin
      has_grant = 1'b1;
      grant_id  = 1'b1;
    end
  end

  // resetn gates issue so nothing leaks onto the bus while reset is held.
  assign issue_ok    = resetn && (count < CW'(MAX_OUTSTANDING));
  assign grant_valid = grant_id ? m1.req.valid : m0.req.valid;
  assign s_valid     = issue_ok && has_grant && grant_valid;
  assign push        = s_valid && s.resp.addr_ok;
  assign pop         = s.resp.data_ok && (count != '0);
  assign head_id     = fifo[head];
  assign busy        = (count != '0);

  always_comb begin
    s.req       = (issue_ok && has_grant && grant_id) ? m1.req : m0.req;
    s.req.valid = s_valid;
  end

  always_comb begin
    m0.resp         = s.resp;
    m0.resp.addr_ok = s.resp.addr_ok && issue_ok && has_grant && !grant_id && m0.req.valid;
    m0.resp.data_ok = pop && !head_id;
  end

  always_comb begin
    m1.resp         = s.resp;
    m1.resp.addr_ok = s.resp.addr_ok && issue_ok && has_grant && grant_id && m1.req.valid;
    m1.resp.data_ok = pop && head_id;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (push) begin
        lock <= 1'b0;
      end else if (s_valid) begin
        lock    <= 1'b1;
        lock_id <= grant_id;
      end

      if ((s.resp.data_ok && count == '0) || (s.resp.addr_ok && lock && !grant_valid))
        err <= 1'b1;
    end
  end

`ifdef SRAMX_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   rr <= 1'b0;
    else if (push) rr <= grant_id;
  end
`endif

  // NOTE: owner storage has no reset; an entry is only read while count marks it live.
  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= grant_id;
  end

endmodule

// File: tb/tb_sramx_arbiter.sv
// Self-checking bench for sramx_arbiter: directed test-plan steps plus a random phase,
// all compared against a queue-based owner/lock model of the bus rules.
module tb_sramx_arbiter;
  import sramx_arbiter_pkg::*;

  localparam int MAXO = 4;
`ifdef SRAMX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  sramx_arbiter_if m0_if ();
  sramx_arbiter_if m1_if ();
  sramx_arbiter_if s_if ();

  sramx_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .m0     (m0_if),
    .m1     (m1_if),
    .s      (s_if),
    .busy   (busy),
    .err    (err)
  );

  int checks = 0;
  int errors = 0;

  // Model: outstanding owners in order, the master holding the bus, last accepted master, sticky err.
  int owners[$];
  int held      = -1;
  int rr_last   = 0;
  bit err_m     = 1'b0;
  int last_push = -1;
  int grants[$];
  int deliv[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input bit v, input logic [31:0] a);
    req_t r;
    r       = '0;
    r.valid = v;
    r.wr    = a[4];
    r.size  = 2'd2;
    r.addr  = a;
    r.wstrb = a[3:0];
    r.wdata = ~a;
    return r;
  endfunction

  task automatic drive(input bit m0v, input logic [31:0] a0, input bit m1v, input logic [31:0] a1,
                       input bit aok, input bit dok, input logic [31:0] d);
    m0_if.req         = mk(m0v, a0);
    m1_if.req         = mk(m1v, a1);
    s_if.resp.addr_ok = aok;
    s_if.resp.data_ok = dok;
    s_if.resp.data    = d;
  endtask

  // Checks every output for the current cycle, then advances the model across the clock edge.
  task automatic cyc(input string tag);
    int   g;
    bit   has, m0v, m1v, aok, dok, issue, gv, sv;
    bit   e_m0d, e_m1d;
    req_t e_req;
    #1;
    m0v = m0_if.req.valid;
    m1v = m1_if.req.valid;
    aok = s_if.resp.addr_ok;
    dok = s_if.resp.data_ok;
    if (!resetn) begin
      chk({tag, ".rst_svalid"}, s_if.req.valid, 0);
      chk({tag, ".rst_oks"}, {m0_if.resp.addr_ok, m0_if.resp.data_ok,
                              m1_if.resp.addr_ok, m1_if.resp.data_ok}, 0);
      chk({tag, ".rst_busy_err"}, {busy, err}, 0);
      owners.delete();
      held = -1; rr_last = 0; err_m = 1'b0; last_push = -1;
      @(posedge clk);
      #1;
      return;
    end
    has = 1'b1;
    g   = 0;
    if (held >= 0)          g = held;
    else if (m0v && m1v)    g = RR ? 1 - rr_last : 0;
    else if (m0v)           g = 0;
    else if (m1v)           g = 1;
    else                    has = 1'b0;
    issue = owners.size() < MAXO;
    gv    = (g == 0) ? m0v : m1v;
    sv    = issue && has && gv;
    e_req = (issue && has && g == 1) ? m1_if.req : m0_if.req;
    e_req.valid = sv;
    e_m0d = dok && owners.size() > 0 && owners[0] == 0;
    e_m1d = dok && owners.size() > 0 && owners[0] == 1;
    chk({tag, ".s_req"}, s_if.req, e_req);
    chk({tag, ".m0_resp"}, m0_if.resp,
        {aok && issue && has && g == 0 && m0v, e_m0d, s_if.resp.data});
    chk({tag, ".m1_resp"}, m1_if.resp,
        {aok && issue && has && g == 1 && m1v, e_m1d, s_if.resp.data});
    chk({tag, ".busy"}, busy, owners.size() > 0);
    chk({tag, ".err"}, err, err_m);
    @(posedge clk);
    if (dok && owners.size() == 0) err_m = 1'b1;
    if (aok && held >= 0 && !gv)   err_m = 1'b1;
    if (dok && owners.size() > 0)  deliv.push_back(owners.pop_front());
    last_push = -1;
    if (sv && aok) begin
      owners.push_back(g);
      grants.push_back(g);
      rr_last   = g;
      held      = -1;
      last_push = g;
    end else if (sv) begin
      held = g;
    end
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 32'h0);
      cyc(tag);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * MAXO && owners.size() > 0; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'h1000 + i);
      cyc(tag);
    end
  endtask

  initial begin
    int n;
    bit v0, v1;
    logic [31:0] a0, a1;

    // Reset state
    resetn = 1'b0;
    drive(1, 32'h40, 1, 32'h80, 1, 1, 32'h0);
    cyc("reset");
    cyc("reset");
    idle(1, "reset");
    resetn = 1'b1;
    idle(1, "post_reset");

    // Single issue: addr_ok in cycle 1, data_ok in cycle 3
    drive(1, 32'h100, 0, 0, 0, 0, 32'h0);          cyc("single.c0");
    chk("single.busy_c1", busy, 0);
    drive(1, 32'h100, 0, 0, 1, 0, 32'h0);          cyc("single.c1");
    chk("single.busy_c2", busy, 1);
    drive(0, 0, 0, 0, 0, 0, 32'h0);                cyc("single.c2");
    drive(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    #1;
    chk("single.m0_data", {m0_if.resp.data_ok, m0_if.resp.data}, {1'b1, 32'hDEADBEEF});
    chk("single.m1_dok", m1_if.resp.data_ok, 0);
    cyc("single.c3");
    idle(1, "single.c4");
    chk("single.busy_c5", busy, 0);

    // Lock hold: m1 waits three cycles, m0 arrives meanwhile
    n = grants.size();
    drive(0, 0, 1, 32'h200, 0, 0, 32'h0);          cyc("lock.c0");
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h300, 1, 32'h200, 0, 0, 32'h0);
      #1;
      chk("lock.s_addr", s_if.req.addr, 32'h200);
      cyc("lock.hold");
    end
    drive(1, 32'h300, 1, 32'h200, 1, 0, 32'h0);    cyc("lock.accept");
    drive(1, 32'h300, 0, 0, 1, 0, 32'h0);          cyc("lock.m0");
    chk("lock.order", {grants[n], grants[n+1]}, {32'd1, 32'd0});
    drain("lock.drain");

    // Interleaved ownership
    n = deliv.size();
    drive(1, 32'h400, 0, 0, 1, 0, 32'h0);          cyc("inter.i0");
    drive(0, 0, 1, 32'h500, 1, 0, 32'h0);          cyc("inter.i1");
    drive(1, 32'h404, 0, 0, 1, 0, 32'h0);          cyc("inter.i2");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'hA0 + i);
      cyc("inter.d");
    end
    chk("inter.order", {deliv[n], deliv[n+1], deliv[n+2]}, {32'd0, 32'd1, 32'd0});

    // Full stall: fifth request waits, full blocks even on a popping cycle
    for (int i = 0; i < MAXO; i++) begin
      drive(i[0], 32'h600 + i, !i[0], 32'h700 + i, 1, 0, 32'h0);
      cyc("full.fill");
    end
    drive(1, 32'h800, 0, 0, 1, 0, 32'h0);
    #1;
    chk("full.blocked", {s_if.req.valid, m0_if.resp.addr_ok}, 0);
    cyc("full.stall");
    drive(1, 32'h800, 0, 0, 1, 1, 32'hB0);
    #1;
    chk("full.pop_cycle", s_if.req.valid, 0);
    cyc("full.pop");
    drive(1, 32'h800, 0, 0, 1, 0, 32'h0);
    #1;
    chk("full.fifth", {s_if.req.valid, m0_if.resp.addr_ok}, 2'b11);
    cyc("full.issue");
    drain("full.drain");

    // Fairness: both masters always valid, slave always ready
    n = grants.size();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h900 + i, 1, 32'hA00 + i, 1, owners.size() > 0, 32'hC0 + i);
      cyc("fair");
    end
    for (int i = n; i + 1 < grants.size(); i++) begin
      if (RR) chk("fair.alt", grants[i+1], 1 - grants[i]);
      else    chk("fair.m0", grants[i], 0);
    end
    drain("fair.drain");

    // Random traffic: masters hold a request until accepted, slave data_ok only when something is outstanding
    v0 = 0; v1 = 0; a0 = 0; a1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!v0 || last_push == 0) begin v0 = $urandom_range(0, 1); a0 = $urandom; end
      if (!v1 || last_push == 1) begin v1 = $urandom_range(0, 1); a1 = $urandom; end
      drive(v0, a0, v1, a1, $urandom_range(0, 1), owners.size() > 0 && $urandom_range(0, 1) == 1,
            $urandom);
      cyc("rand");
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    n = 0;
    while (held >= 0 && n < 4) begin
      drive(held == 0, a0, held == 1, a1, 1, 0, 32'h0);
      cyc("rand.flush");
      n++;
    end
    drain("rand.drain");
    chk("rand.err_clear", err, 0);

    // Error: stray data_ok, then locked master withdrawing
    n = deliv.size();
    drive(0, 0, 0, 0, 0, 1, 32'h55);
    #1;
    chk("err.stray_dok", {m0_if.resp.data_ok, m1_if.resp.data_ok}, 0);
    cyc("err.stray");
    chk("err.set", err, 1);
    idle(2, "err.hold");
    chk("err.sticky", err, 1);
    drive(0, 0, 1, 32'hE00, 0, 0, 32'h0);          cyc("err.lock");
    drive(0, 0, 0, 0, 1, 0, 32'h0);                cyc("err.withdraw");
    drive(0, 0, 1, 32'hE00, 1, 0, 32'h0);          cyc("err.accept");

    // Reset mid-stream with two outstanding
    drive(1, 32'hF00, 0, 0, 1, 0, 32'h0);          cyc("rst.i0");
    chk("rst.outstanding", busy, 1);
    drive(1, 32'hF04, 1, 32'hF08, 1, 1, 32'h66);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst.immediate", {busy, err, s_if.req.valid, m0_if.resp.addr_ok, m0_if.resp.data_ok,
                          m1_if.resp.addr_ok, m1_if.resp.data_ok}, 0);
    cyc("rst.hold");
    resetn = 1'b1;
    n = deliv.size();
    drive(0, 0, 0, 0, 0, 1, 32'h77);               cyc("rst.after");
    chk("rst.no_dok", deliv.size(), n);
    idle(2, "rst.tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sramx_arbiter.md
Name: sramx_arbiter

Overview:
- Two-master to one-slave arbiter for the sramx-style split-handshake bus. The request handshake is valid/addr_ok; the response handshake is data_ok.
- Sits between the CPU's ibus-side and dbus-side request ports and the single shared bus toward the cache/AXI bridge.
- Tracks which master owns each outstanding transaction, so in-order data_ok responses are steered back to the correct master.

Parameters:
- req_t, dbus_req_t: request struct type; must contain a valid field.
- resp_t, dbus_resp_t: response struct type; must contain addr_ok, data_ok and data fields.
- MAX_OUTSTANDING, 4: depth of the owner-ID FIFO. Must be a power of two, at least 2.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- resetn, input, 1: asynchronous active-low reset.
- m0_req, input, req_t: master 0 request (dbus side). Master 0 has fixed priority by default.
- m0_resp, output, resp_t: master 0 response.
- m1_req, input, req_t: master 1 request (ibus side).
- m1_resp, output, resp_t: master 1 response.
- s_req, output, req_t: request to the shared slave.
- s_resp, input, resp_t: response from the shared slave.
- busy, output, 1: high when at least one transaction is outstanding.
- err, output, 1: sticky protocol-error flag.

Behaviour:
- Reset: asynchronous on resetn low.
  - Clears the FIFO (head = tail = count = 0), lock, lock_id, rr pointer and err.
  - While resetn is low: s_req.valid = 0, both m*_resp addr_ok/data_ok = 0, busy = 0, err = 0.
  - A reset mid-operation drops all outstanding transactions. No data_ok is forwarded for them.
- Grant selection:
  - If lock = 1, grant = lock_id.
  - Otherwise grant = 0 if m0_req.valid; else grant = 1 if m1_req.valid; else no grant.
- Issue gating (issue_ok):
  - count < MAX_OUTSTANDING.
  - When the FIFO is full, s_req.valid = 0 and neither master sees addr_ok. Full blocks issue even if data_ok pops in that same cycle.
- s_req:
  - Equals the granted master's req when issue_ok and a grant exists.
  - Otherwise equals m0_req with valid forced to 0.
- m_i_resp: s_resp passed through, except:
  - addr_ok = s_resp.addr_ok AND issue_ok AND grant == i AND m_i_req.valid.
  - data_ok = s_resp.data_ok AND count != 0 AND fifo[head] == i.
  - data is broadcast to both masters.
- Lock (keeps a presented request stable until accepted, as the sramx rules require):
  - Set when s_req.valid AND NOT s_resp.addr_ok: lock <= 1, lock_id <= grant.
  - Cleared on the cycle s_req.valid AND s_resp.addr_ok.
  - A higher-priority request arriving while locked waits.
- FIFO push: on s_req.valid AND s_resp.addr_ok, fifo[tail] <= grant, tail++.
- FIFO pop: on s_resp.data_ok AND count != 0, head++.
- FIFO pointers: width log2(MAX_OUTSTANDING), natural wrap-around.
- Count update:
  - count + 1 on push only.
  - count - 1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal whenever count is between 1 and MAX_OUTSTANDING - 1.
- Same-cycle addr_ok and data_ok: the slave guarantees data_ok for a transaction comes at least one cycle after its addr_ok. A same-cycle data_ok therefore always belongs to the old head.
- err is set and held until reset on either of:
  - s_resp.data_ok while count == 0 (the data_ok is dropped, no master sees it);
  - s_resp.addr_ok while lock == 1 and the locked master's valid has dropped.
- busy = (count != 0), registered-state derived. No combinational path from the m*_req inputs to busy.
- Latency: zero added cycles; request and response paths are combinational through the arbiter.

Optional Feature:
- Macro: SRAMX_ARB_RR_EN.
- Defined: round-robin grant.
  - rr pointer holds the last master that completed an addr_ok handshake.
  - When unlocked and both masters are valid, grant goes to the master that is not rr.
  - rr updates on each push.
- Undefined: fixed priority, master 0 over master 1. No rr register is synthesised.

Test Plan:
- Single issue: m0 valid with addr 0x100, slave addr_ok in cycle 1 and data_ok with data 0xDEADBEEF in cycle 3.
  - Expect m0_resp.addr_ok in cycle 1 only.
  - Expect m0_resp.data_ok with 0xDEADBEEF in cycle 3; m1_resp.data_ok stays 0.
  - Expect busy high in cycles 2-3 only.
- Lock hold: m1 valid alone, slave withholds addr_ok 3 cycles; m0 asserts valid in cycle 1.
  - Expect s_req to stay m1's request until addr_ok.
  - Expect m0 to be granted the following cycle.
- Interleaved ownership: issue m0, m1, m0 back-to-back with addr_ok=1, then 3 data_ok pulses.
  - Expect data_ok delivered to m0, m1, m0 in that order.
- Full stall: MAX_OUTSTANDING=4, 4 accepted issues with no data_ok.
  - Expect the 5th request to see s_req.valid=0 and no addr_ok.
  - After one data_ok, expect the 5th to issue on the next cycle.
- Fairness: both masters continuously valid, slave always addr_ok.
  - Without SRAMX_ARB_RR_EN: all grants go to m0.
  - With SRAMX_ARB_RR_EN: grants alternate 0,1,0,1.
- Error/reset:
  - data_ok with count=0 -> err=1 and held; no master sees data_ok.
  - Then resetn low mid-stream with 2 outstanding -> busy=0 and err=0 immediately; no data_ok forwarded after release.
